// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for the shared 64-bit integer ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP; the result is held until its owner takes it.
module alu_share_arbiter #(
    parameter int XLEN = 64,
    parameter int SELW = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [SELW-1:0] req0_sel,
    input  logic            req0_sladd,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [SELW-1:0] req1_sel,
    input  logic            req1_sladd,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [SELW-1:0] alu_sel,
    output logic            alu_sladd,
    output logic            alu_select,
    input  logic [XLEN-1:0] alu_result,
    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic            last_grant_reg;
    logic            owner_reg;
    logic [XLEN-1:0] in1_reg;
    logic [XLEN-1:0] in2_reg;
    logic [SELW-1:0] sel_reg;
    logic            sladd_reg;
    logic [XLEN-1:0] result_reg;

    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            owner_ready;
    logic [1:0]      rsp_valid_vec;
    logic [1:0]      rsp_ready_vec;
    logic [XLEN-1:0] rsp_data_arr [2];

    // When both ask, the one that did not win last time gets the ALU.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_reg);
        grant1 = req1_valid && (!req0_valid || !last_grant_reg);
    end

    assign req0_ready    = (state_reg == IDLE) && grant0;
    assign req1_ready    = (state_reg == IDLE) && grant1;
    assign accept        = req0_ready || req1_ready;
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
    assign owner_ready   = rsp_ready_vec[owner_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (owner_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg      <= grant1;
                last_grant_reg <= grant1;
            end
        end
    end

    // Operands only move on a handshake so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_reg   <= '0;
            in2_reg   <= '0;
            sel_reg   <= '0;
            sladd_reg <= 1'b0;
        end else if (accept) begin
            in1_reg   <= grant1 ? req1_in1   : req0_in1;
            in2_reg   <= grant1 ? req1_in2   : req0_in2;
            sel_reg   <= grant1 ? req1_sel   : req0_sel;
            sladd_reg <= grant1 ? req1_sladd : req0_sladd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
        end else if (state_reg == EXEC) begin
            result_reg <= alu_result;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
            assign rsp_data_arr[gi]  = rsp_valid_vec[gi] ? result_reg : '0;
        end
    endgenerate

    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_data  = rsp_data_arr[0];
    assign rsp1_data  = rsp_data_arr[1];

    assign alu_in1    = in1_reg;
    assign alu_in2    = in2_reg;
    assign alu_sel    = sel_reg;
    assign alu_sladd  = sladd_reg;
    assign alu_select = (state_reg == EXEC);
    assign busy       = (state_reg != IDLE);

endmodule
